uart_cmd_parser: RTL and testbench

//  Byte-stream command decoder placed directly downstream of the housekeeper UART receiver.

---
 rtl/uart_cmd_parser_pkg.sv | 23 ++
 rtl/uart_cmd_parser_if.sv | 11 +
 rtl/uart_cmd_parser_timeout.sv | 24 ++
 rtl/uart_cmd_parser.sv | 141 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and default frame constants for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_OP_WRITE  = 8'h57;
  localparam logic [7:0] DEF_OP_READ   = 8'h52;

  typedef enum logic [2:0] {
    HUNT,
    OP,
    ADDR,
    DATA,
    CSUM,
    ISSUE
  } state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        wr;
  } req_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Register-bus request channel: the parser is master, the register block is slave.
interface uart_cmd_parser_if;
  logic [7:0]  BusAddr;
  logic [31:0] BusWData;
  logic        BusWr;
  logic        BusValid;
  logic        BusReady;

  modport master (output BusAddr, BusWData, BusWr, BusValid, input BusReady);
  modport slave  (input BusAddr, BusWData, BusWr, BusValid, output BusReady);
endinterface

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte idle counter; expire is high for the one cycle the count would reach TIMEOUT_CYCLES.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) count <= '0;
    else                   count <= count + 1'b1;
  end

  // A byte in the expiry cycle clears the counter and suppresses the expiry.
  assign expire = en && !clr && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-stream frame decoder issuing register-bus requests.
// Optional trailing XOR checksum byte: define UART_CMD_CHECKSUM_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0]  OP_WRITE       = DEF_OP_WRITE,
  parameter logic [7:0]  OP_READ        = DEF_OP_READ,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [7:0]         RxD,
  input  logic               RxDValid,
  uart_cmd_parser_if.master  bus,
  output logic               FrameErr,
  output logic               Overrun,
  output logic               Busy
);

`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t PAYLOAD_DONE = CSUM;
  logic [7:0] csum;
`else
  localparam state_t PAYLOAD_DONE = ISSUE;
`endif

  state_t     state;
  req_t       req;
  logic [1:0] idx;
  logic       bus_valid;
  logic       frame_err;
  logic       overrun;
  logic       tmo_en;
  logic       expire;

  assign tmo_en = (state == OP) || (state == ADDR) || (state == DATA) || (state == CSUM);

  uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (RxDValid),
    .en     (tmo_en),
    .expire (expire)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= HUNT;
      req       <= '0;
      idx       <= '0;
      bus_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (expire) begin
        frame_err <= 1'b1;
        state     <= HUNT;
      end else begin
        case (state)
          HUNT: begin
`ifdef UART_CMD_CHECKSUM_EN
            csum <= '0;
`endif
            if (RxDValid && RxD == SYNC_BYTE) state <= OP;
          end
          OP: if (RxDValid) begin
            if (RxD == OP_WRITE || RxD == OP_READ) begin
              req.wr <= (RxD == OP_WRITE);
`ifdef UART_CMD_CHECKSUM_EN
              csum   <= csum ^ RxD;
`endif
              state  <= ADDR;
            end else begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end
          end
          ADDR: if (RxDValid) begin
            req.addr <= RxD;
            idx      <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            csum     <= csum ^ RxD;
`endif
            if (req.wr) begin
              state <= DATA;
            end else begin
              state     <= PAYLOAD_DONE;
              bus_valid <= (PAYLOAD_DONE == ISSUE);
            end
          end
          DATA: if (RxDValid) begin
            req.wdata[8*idx +: 8] <= RxD;
            idx                   <= idx + 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
            csum                  <= csum ^ RxD;
`endif
            if (idx == 2'd3) begin
              state     <= PAYLOAD_DONE;
              bus_valid <= (PAYLOAD_DONE == ISSUE);
            end
          end
`ifdef UART_CMD_CHECKSUM_EN
          CSUM: if (RxDValid) begin
            if (RxD == csum) begin
              state     <= ISSUE;
              bus_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end
          end
`endif
          ISSUE: begin
            // Bytes here are dropped, even in the accept cycle.
            if (RxDValid) overrun <= 1'b1;
            if (bus.BusReady) begin
              bus_valid <= 1'b0;
              state     <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.BusAddr  = req.addr;
  assign bus.BusWData = req.wdata;
  assign bus.BusWr    = req.wr;
  assign bus.BusValid = bus_valid;
  assign FrameErr     = frame_err;
  assign Overrun      = overrun;
  assign Busy         = (state != HUNT);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser; builds with or without UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_parser;

  localparam int unsigned T = 20;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] RxD;
  logic       RxDValid;
  logic       FrameErr, Overrun, Busy;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .RxD      (RxD),
    .RxDValid (RxDValid),
    .bus      (bus),
    .FrameErr (FrameErr),
    .Overrun  (Overrun),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the next posedge, returns at the following negedge.
  task automatic send(input logic [7:0] b);
    RxD = b;
    RxDValid = 1'b1;
    @(negedge Clk);
    RxDValid = 1'b0;
    RxD = 8'h00;
  endtask

  task automatic send_csum(input logic [7:0] b);
    if (CSUM_ON) send(b);
  endtask

  initial begin
    Rst = 1'b1; RxD = 8'h00; RxDValid = 1'b0; bus.BusReady = 1'b0;
    repeat (2) @(negedge Clk);
    check_eq("rst_valid", bus.BusValid, 0);
    check_eq("rst_ferr",  FrameErr, 0);
    check_eq("rst_ovr",   Overrun, 0);
    check_eq("rst_busy",  Busy, 0);
    check_eq("rst_addr",  bus.BusAddr, 0);
    check_eq("rst_wdata", bus.BusWData, 0);
    check_eq("rst_wr",    bus.BusWr, 0);
    Rst = 1'b0;
    @(negedge Clk);

    // 1: write frame, immediately accepted (XOR of 57 10 EF BE AD DE = 65)
    bus.BusReady = 1'b1;
    send(8'hA5); send(8'h57); send(8'h10); send(8'hEF); send(8'hBE); send(8'hAD);
    check_eq("w_early_valid", bus.BusValid, 0);
    send(8'hDE); send_csum(8'h65);
    check_eq("w_valid", bus.BusValid, 1);
    check_eq("w_addr",  bus.BusAddr, 32'h10);
    check_eq("w_wdata", bus.BusWData, 32'hDEADBEEF);
    check_eq("w_wr",    bus.BusWr, 1);
    @(negedge Clk);
    check_eq("w_drop",  bus.BusValid, 0);
    check_eq("w_idle",  Busy, 0);

    // 2: read frame with 5 stalled cycles
    bus.BusReady = 1'b0;
    send(8'h00); send(8'hA5); send(8'h52); send(8'h20); send_csum(8'h72);
    check_eq("r_wdata_kept", bus.BusWData, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      check_eq("r_hold_valid", bus.BusValid, 1);
      check_eq("r_hold_addr",  bus.BusAddr, 32'h20);
      check_eq("r_hold_wr",    bus.BusWr, 0);
      if (i == 5) bus.BusReady = 1'b1;
      @(negedge Clk);
    end
    check_eq("r_drop", bus.BusValid, 0);
    check_eq("r_idle", Busy, 0);

    // 3: bad opcode, then a good read
    send(8'hA5); send(8'h33);
    check_eq("op_ferr",   FrameErr, 1);
    check_eq("op_busy",   Busy, 0);
    @(negedge Clk);
    check_eq("op_ferr_1", FrameErr, 0);
    check_eq("op_valid",  bus.BusValid, 0);
    send(8'hA5); send(8'h52); send(8'h01); send_csum(8'h53);
    check_eq("op_rd_valid", bus.BusValid, 1);
    check_eq("op_rd_addr",  bus.BusAddr, 32'h01);
    @(negedge Clk);
    check_eq("op_rd_drop",  bus.BusValid, 0);

    // 4: timeout after T idle cycles
    send(8'hA5); send(8'h57); send(8'h10);
    repeat (T - 1) @(negedge Clk);
    check_eq("to_before", FrameErr, 0);
    check_eq("to_busy",   Busy, 1);
    @(negedge Clk);
    check_eq("to_ferr",   FrameErr, 1);
    check_eq("to_hunt",   Busy, 0);
    @(negedge Clk);
    check_eq("to_ferr_1", FrameErr, 0);
    // byte on the expiry cycle keeps the frame alive
    send(8'hA5); send(8'h57); send(8'h10);
    repeat (T - 1) @(negedge Clk);
    send(8'hEF);
    check_eq("to_edge_ferr", FrameErr, 0);
    check_eq("to_edge_busy", Busy, 1);
    send(8'hBE); send(8'hAD); send(8'hDE); send_csum(8'h65);
    check_eq("to_edge_valid", bus.BusValid, 1);
    check_eq("to_edge_wdata", bus.BusWData, 32'hDEADBEEF);
    @(negedge Clk);

    // 5: overrun while pending, and in the accept cycle
    bus.BusReady = 1'b0;
    send(8'hA5); send(8'h52); send(8'h30); send_csum(8'h62);
    send(8'h5A);
    check_eq("ov_pulse", Overrun, 1);
    check_eq("ov_valid", bus.BusValid, 1);
    check_eq("ov_addr",  bus.BusAddr, 32'h30);
    check_eq("ov_wr",    bus.BusWr, 0);
    @(negedge Clk);
    check_eq("ov_pulse_1", Overrun, 0);
    bus.BusReady = 1'b1;
    send(8'hA5);
    check_eq("ov_acc_pulse", Overrun, 1);
    check_eq("ov_acc_valid", bus.BusValid, 0);
    send(8'h52); send(8'h44); send_csum(8'h16);
    check_eq("ov_nosync_valid", bus.BusValid, 0);
    check_eq("ov_nosync_busy",  Busy, 0);

`ifdef UART_CMD_CHECKSUM_EN
    // 6a: checksum mismatch
    send(8'hA5); send(8'h52); send(8'h20); send(8'h00);
    check_eq("cs_ferr",  FrameErr, 1);
    check_eq("cs_valid", bus.BusValid, 0);
    @(negedge Clk);
`endif

    // 6b: reset in the middle of DATA
    send(8'hA5); send(8'h57); send(8'h77); send(8'hEF);
    Rst = 1'b1;
    @(negedge Clk);
    check_eq("mr_busy",  Busy, 0);
    check_eq("mr_addr",  bus.BusAddr, 0);
    check_eq("mr_wdata", bus.BusWData, 0);
    check_eq("mr_wr",    bus.BusWr, 0);
    check_eq("mr_ferr",  FrameErr, 0);
    Rst = 1'b0;
    send(8'hBE); send(8'hAD); send(8'hDE);
    check_eq("mr_after_busy",  Busy, 0);
    check_eq("mr_after_valid", bus.BusValid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
